// File: rtl/dmem_pkg.sv
// Shared types and helpers for the synchronous data memory (dmem_sync).
package dmem_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res++;
        end
        return res;
    endfunction

    // Geometry of the default 64-bit x 1024-word configuration
    localparam int BYTES    = 64 / 8;
    localparam int OFS_BITS = clog2(BYTES);
    localparam int IDX_BITS = clog2(1024);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } wait_state_t;

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-response delay line: STAGES-deep shift of {valid, err, data}.
// The last stage holds its data while no response is present.
module dmem_rd_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [STAGES-1:0]     vld_p;
    logic [STAGES-1:0]     err_p;
    logic [DATA_WIDTH-1:0] data_p [STAGES];

    // Error bits only ever travel with a valid slot, so out_err is self-qualified
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            err_p <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= in_vld;
            err_p[0] <= in_vld & in_err;
            if (in_vld) begin
                data_p[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
                err_p[i] <= err_p[i-1];
                if (vld_p[i-1]) begin
                    data_p[i] <= data_p[i-1];
                end
            end
        end
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_err  = err_p[STAGES-1];
    assign out_data = data_p[STAGES-1];

endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory with valid/ready requests, byte strobes and a
// configurable read latency. Define DMEM_WAIT_STATE_EN to insert wait states.
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int DEPTH       = 1024,
    parameter int RD_LATENCY  = 1,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    in_Clk,
    input  logic                    in_Rst_n,
    input  logic                    in_req_valid,
    output logic                    out_req_ready,
    input  logic                    in_wr_en,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_wr_data,
    input  logic [DATA_WIDTH/8-1:0] in_byte_en,
    output logic                    out_rsp_valid,
    output logic [DATA_WIDTH-1:0]   out_rd_data,
    output logic                    out_rsp_err
);

    localparam int N_BYTES = DATA_WIDTH / 8;
    localparam int OFS     = clog2(N_BYTES);
    localparam int IDX     = clog2(DEPTH);

    if (RD_LATENCY < 1 || RD_LATENCY > 4 || (DATA_WIDTH % 8) != 0 || WAIT_CYCLES < 0) begin : g_bad_cfg
        $error("dmem_sync: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX-1:0]        idx;
    logic                  oor;
    logic                  req_ready;
    logic                  accept;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_addr_lsb;

    assign idx             = in_addr[OFS +: IDX];
    assign unused_addr_lsb = ^in_addr[OFS-1:0];

    if (ADDR_WIDTH > OFS + IDX) begin : g_oor
        assign oor = |in_addr[ADDR_WIDTH-1:OFS+IDX];
    end else begin : g_no_oor
        assign oor = 1'b0;
    end

    assign accept = in_req_valid & req_ready;
    assign wr_acc = accept & in_wr_en & ~oor;
    assign rd_acc = accept & ~in_wr_en;

`ifdef DMEM_WAIT_STATE_EN
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : clog2(WAIT_CYCLES + 1);

    wait_state_t      state;
    logic [CNT_W-1:0] wait_cnt;

    // Ready is registered: it is raised on the edge that enters GRANT
    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b0;
                    if (in_req_valid) begin
                        if (WAIT_CYCLES == 0) begin
                            state     <= GRANT;
                            req_ready <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        state     <= GRANT;
                        req_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                GRANT: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            req_ready <= 1'b0;
        end else begin
            req_ready <= 1'b1;
        end
    end
`endif

    assign out_req_ready = req_ready;

    // Storage is deliberately left out of reset so contents survive it
    always_ff @(posedge in_Clk) begin
        if (wr_acc) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (in_byte_en[b]) begin
                    mem[idx][b*8 +: 8] <= in_wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_word = oor ? '0 : mem[idx];

    dmem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY)
    ) u_rd_pipe (
        .clk      (in_Clk),
        .rst_n    (in_Rst_n),
        .in_vld   (rd_acc),
        .in_err   (oor),
        .in_data  (rd_word),
        .out_vld  (out_rsp_valid),
        .out_err  (out_rsp_err),
        .out_data (out_rd_data)
    );

endmodule

// File: tb/tb_dmem_sync.sv
// Directed bench for dmem_sync with a response scoreboard and a byte-lane memory model.
module tb_dmem_sync;

    localparam int LAT  = 3;
    localparam int WC   = 2;
`ifdef DMEM_WAIT_STATE_EN
    localparam int SPACING = WC + 2;
`else
    localparam int SPACING = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        wr_en = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  byte_en = '0;
    logic        rsp_valid;
    logic [63:0] rd_data;
    logic        rsp_err;

    dmem_sync #(
        .DATA_WIDTH  (64),
        .ADDR_WIDTH  (64),
        .DEPTH       (1024),
        .RD_LATENCY  (LAT),
        .WAIT_CYCLES (WC)
    ) dut (
        .in_Clk        (clk),
        .in_Rst_n      (rst_n),
        .in_req_valid  (req_valid),
        .out_req_ready (req_ready),
        .in_wr_en      (wr_en),
        .in_addr       (addr),
        .in_wr_data    (wr_data),
        .in_byte_en    (byte_en),
        .out_rsp_valid (rsp_valid),
        .out_rd_data   (rd_data),
        .out_rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t        sb[$];
    logic [63:0] model [1024];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_checks = 0;
    logic [63:0] last_data = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Responses are compared against the scoreboard; idle cycles must hold data and keep err low
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = '0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_data", rd_data, e.data);
                check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                check("rsp_cycle", 64'(cyc), 64'(e.due));
            end
            last_data = rd_data;
        end else begin
            check("idle_err", {63'd0, rsp_err}, 64'd0);
            check("idle_hold", rd_data, last_data);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic do_req(input logic wr, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] be, input bit expect_rsp, output int acc);
        int   t;
        rsp_t e;
        logic oor;
        req_valid = 1'b1;
        wr_en     = wr;
        addr      = a;
        wr_data   = d;
        byte_en   = be;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("ready_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            acc = -1;
            @(negedge clk);
            return;
        end
        acc = cyc + 1;
        oor = (a[63:13] != '0);
        if (wr) begin
            if (!oor) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) model[a[12:3]][b*8 +: 8] = d[b*8 +: 8];
                end
            end
        end else if (expect_rsp) begin
            e.data = oor ? 64'd0 : model[a[12:3]];
            e.err  = oor;
            e.due  = acc + LAT - 1;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        wr_en     = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int acc [4];
        int a0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, req_ready}, 64'd0);
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_data", rd_data, 64'd0);
        check("rst_err", {63'd0, rsp_err}, 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
`ifdef DMEM_WAIT_STATE_EN
        check("ready_after_rst", {63'd0, req_ready}, 64'd0);
`else
        check("ready_after_rst", {63'd0, req_ready}, 64'd1);
`endif

        // Full write then read
        do_req(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 1'b0, a0);
        do_req(1'b0, 64'h10, 64'd0, 8'h00, 1'b1, a0);
        go_idle();
        drain();

        // Partial byte-lane write
        do_req(1'b1, 64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b0, a0);
        do_req(1'b0, 64'h10, 64'd0, 8'hFF, 1'b1, a0);
        go_idle();
        drain();

        // Back-to-back reads, ready spacing checked between accepts
        do_req(1'b1, 64'h00, 64'h0101_0202_0303_0404, 8'hFF, 1'b0, a0);
        do_req(1'b1, 64'h08, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b0, a0);
        do_req(1'b1, 64'h18, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1'b0, a0);
        go_idle();
        do_req(1'b0, 64'h00, 64'd0, 8'h00, 1'b1, acc[0]);
        do_req(1'b0, 64'h08, 64'd0, 8'h00, 1'b1, acc[1]);
        do_req(1'b0, 64'h10, 64'd0, 8'h00, 1'b1, acc[2]);
        do_req(1'b0, 64'h18, 64'd0, 8'h00, 1'b1, acc[3]);
        go_idle();
        for (int i = 1; i < 4; i++) begin
            check("accept_spacing", 64'(acc[i] - acc[i-1]), 64'(SPACING));
        end
        drain();

        // Out-of-range read and ignored out-of-range write
        do_req(1'b0, 64'h2000, 64'd0, 8'h00, 1'b1, a0);
        do_req(1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, a0);
        do_req(1'b0, 64'h00, 64'd0, 8'h00, 1'b1, a0);
        go_idle();
        drain();

        // Reset with reads in flight: only a read old enough to have answered is expected
        do_req(1'b0, 64'h08, 64'd0, 8'h00, (SPACING > LAT - 1), a0);
        do_req(1'b0, 64'h10, 64'd0, 8'h00, 1'b0, a0);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", {63'd0, rsp_valid}, 64'd0);
        check("midrst_data", rd_data, 64'd0);
        check("midrst_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_rsp", 64'(sb.size()), 64'd0);

        // Contents survive reset
        do_req(1'b0, 64'h10, 64'd0, 8'h00, 1'b1, a0);
        go_idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_sync.md
Name: dmem_sync

Overview:
- Parametrised synchronous data memory that replaces the combinational DMem model used with RV64IFD_top.
- Adds:
  - a valid/ready request handshake
  - byte-lane write strobes
  - a configurable read-latency pipeline
  - out-of-range detection
- Sits between the core's load/store path and storage, in simulation and in FPGA builds.

Parameters:
- DATA_WIDTH, 64, word width in bits; multiple of 8.
- ADDR_WIDTH, 64, byte-address width.
- DEPTH, 1024, number of words; power of two.
- RD_LATENCY, 1, cycles from request acceptance to read data; legal range 1..4.
- WAIT_CYCLES, 2, wait states per request; used only with DMEM_WAIT_STATE_EN.

Ports:
- in_Clk  input  1  clock, rising edge.
- in_Rst_n  input  1  asynchronous, active-low reset.
- in_req_valid  input  1  request present.
- out_req_ready  output  1  request accepted this cycle when high together with in_req_valid.
- in_wr_en  input  1  1 = write, 0 = read.
- in_addr  input  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored.
- in_wr_data  input  DATA_WIDTH  write data.
- in_byte_en  input  DATA_WIDTH/8  write byte strobes; bit i selects byte i.
- out_rsp_valid  output  1  read data valid; one-cycle pulse per read.
- out_rd_data  output  DATA_WIDTH  read data.
- out_rsp_err  output  1  qualifies out_rsp_valid; address was out of range.

Behaviour:
- Reset values: out_req_ready=0, out_rsp_valid=0, out_rd_data=0, out_rsp_err=0. Pipeline valid bits are cleared.
- Memory array is not reset; contents are retained across reset.
- out_req_ready rises in the first cycle after in_Rst_n deasserts. Without the optional feature it then stays 1.
- Accept = in_req_valid & out_req_ready, sampled at the rising edge. At most one request per cycle.
- Word index = in_addr[OFS +: log2(DEPTH)], where OFS = log2(DATA_WIDTH/8).
- Out of range: any in_addr bit at or above OFS + log2(DEPTH) is nonzero.
- Write, in range: on the accepting edge, each byte lane with in_byte_en[i]=1 is updated; other lanes are unchanged.
- Write, out of range: ignored.
- Writes produce no response.
- Read accepted at edge k: out_rsp_valid is high for exactly the cycle following edge k+RD_LATENCY-1.
  - For RD_LATENCY=1 that is the cycle right after acceptance.
  - out_rd_data holds the word as of the accepting edge, after any write accepted at an earlier edge.
  - Write at edge k followed by a read of the same address at edge k+1 returns the new data.
- Out-of-range read: out_rd_data=0, out_rsp_err=1.
- Back-to-back reads are fully pipelined; responses return in order, one per cycle.
- When out_rsp_valid=0: out_rd_data holds its last value and out_rsp_err=0.
- in_byte_en is ignored for reads.
- Reset mid-operation: in-flight reads are discarded, no response is ever produced for them, and the wait FSM returns to IDLE.

Optional Feature:
- Macro: DMEM_WAIT_STATE_EN.
- Defined: 3-state FSM.
  - IDLE: out_req_ready=0. On in_req_valid, go to WAIT and load a counter with WAIT_CYCLES.
  - WAIT: decrement each cycle. At 0, go to GRANT; if WAIT_CYCLES=0, go directly from IDLE to GRANT.
  - GRANT: out_req_ready=1 for one cycle; accept; return to IDLE.
  - Each request therefore sees WAIT_CYCLES+1 cycles of ready-low before acceptance.
  - If in_req_valid drops during WAIT, the FSM still proceeds to GRANT. With no valid request there, nothing is accepted and the FSM returns to IDLE.
- Undefined: no FSM; out_req_ready=1 after reset; WAIT_CYCLES unused.

Decomposition:
- Package dmem_pkg:
  - BYTES = DATA_WIDTH/8
  - OFS_BITS
  - IDX_BITS
  - wait-FSM state encoding (IDLE, WAIT, GRANT)
  - clog2 function
- Sub-module dmem_rd_pipe:
  - RD_LATENCY-deep shift register of {valid, err, data}
  - asynchronously cleared valid bits
  - instantiated once in dmem_sync

Test Plan:
- Reset, then write 64'h1122334455667788 to addr 0x10 with byte_en 8'hFF, then read 0x10 -> out_rsp_valid exactly RD_LATENCY cycles after accept; data 64'h1122334455667788; err 0.
- Write 64'hAAAA_AAAA_AAAA_AAAA to 0x10 with byte_en 8'h0F, then read -> 64'h11223344AAAAAAAA.
- RD_LATENCY=3: four back-to-back reads to 0x0, 0x8, 0x10, 0x18 -> four consecutive response pulses in order, the first 3 cycles after the first accept.
- Read addr DEPTH*8 = 0x2000 -> out_rsp_err=1, data 0. A write to 0x2000 followed by a read of 0x0 shows word 0 unchanged.
- Assert in_Rst_n=0 while two reads are in flight -> no out_rsp_valid pulse after release; a later read of 0x10 returns the pre-reset contents.
- With DMEM_WAIT_STATE_EN and WAIT_CYCLES=2: hold in_req_valid -> out_req_ready pulses once every 4 cycles; accepted reads are still answered RD_LATENCY cycles after their accept.
